// File: rtl/segment_scan_mux.sv
// Time-multiplexed seven-segment digit scanner: snapshots N digit codes and scans them with a
// programmable dwell and blanking gap. Optional macro SEG_LEADING_ZERO_BLANK_EN suppresses leading zeros.
module segment_scan_mux #(
  parameter int NUM_DIGITS = 5,
  parameter int DIGIT_W    = 4,
  parameter int SEL_W      = 3,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 2,
  parameter int BLANK_CODE = 11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          load,
  output logic [DIGIT_W-1:0]            out,
  output logic [SEL_W-1:0]              sel,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic                          frame_done
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_DIGITS - 1);
  localparam logic [DIGIT_W-1:0] BLANK_VAL  = DIGIT_W'(BLANK_CODE);

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic                          started_q, started_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]         snap_en_q, snap_en_d;
  logic [DIGIT_W-1:0]            out_q, out_d;
  logic [NUM_DIGITS-1:0]         an_n_q, an_n_d;
  logic                          frame_done_q, frame_done_d;
  logic                          advance_s;
  logic [NUM_DIGITS-1:0]         en_eff_s;
  logic [DIGIT_W-1:0]            cur_dig_s;
  logic                          cur_en_s;
  logic [NUM_DIGITS-1:0]         one_hot_s;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digit i>0 stays lit only if it or some higher digit is non-zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [NUM_DIGITS*DIGIT_W-1:0] dig);
    logic seen;
    seen    = 1'b0;
    lz_mask = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen       = seen | (dig[i*DIGIT_W +: DIGIT_W] != {DIGIT_W{1'b0}});
      lz_mask[i] = seen;
    end
    lz_mask[0] = 1'b1;
  endfunction
`endif

  always_comb begin
    snap_dig_d = snap_dig_q;
    snap_en_d  = snap_en_q;
    if (load) begin
      snap_dig_d = digits_in;
      snap_en_d  = digit_en;
    end else begin
      snap_dig_d = snap_dig_q;
      snap_en_d  = snap_en_q;
    end
  end

  // The first edge after reset only loads the outputs, so digit 0 gets its full dwell.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    advance_s = 1'b0;
    started_d = 1'b1;
    if (!started_q) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end else begin
      case (state_q)
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            if (BLANK_CYC > 0) begin
              state_d = ST_BLANK;
            end else begin
              state_d   = ST_SHOW;
              advance_s = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d     = {CNT_W{1'b0}};
            state_d   = ST_SHOW;
            advance_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_SHOW;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  always_comb begin
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    if (advance_s) begin
      if (sel_q == SEL_LAST) begin
        sel_d        = {SEL_W{1'b0}};
        frame_done_d = 1'b1;
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end else begin
      sel_d = sel_q;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign en_eff_s = snap_en_d & lz_mask(snap_dig_d);
`else
  assign en_eff_s = snap_en_d;
`endif

  // Outputs are derived from next-state values so they line up with the registered sel.
  always_comb begin
    cur_dig_s = {DIGIT_W{1'b0}};
    cur_en_s  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_dig_s = cur_dig_s | ({DIGIT_W{sel_d == SEL_W'(i)}} & snap_dig_d[i*DIGIT_W +: DIGIT_W]);
      cur_en_s  = cur_en_s | ((sel_d == SEL_W'(i)) & en_eff_s[i]);
    end
    one_hot_s = NUM_DIGITS'(1) << sel_d;
    if ((state_d == ST_SHOW) && cur_en_s) begin
      out_d  = cur_dig_s;
      an_n_d = ~one_hot_s;
    end else begin
      out_d  = BLANK_VAL;
      an_n_d = {NUM_DIGITS{1'b1}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SHOW;
      cnt_q        <= {CNT_W{1'b0}};
      sel_q        <= {SEL_W{1'b0}};
      started_q    <= 1'b0;
      snap_dig_q   <= {(NUM_DIGITS*DIGIT_W){1'b0}};
      snap_en_q    <= {NUM_DIGITS{1'b0}};
      out_q        <= BLANK_VAL;
      an_n_q       <= {NUM_DIGITS{1'b1}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      started_q    <= started_d;
      snap_dig_q   <= snap_dig_d;
      snap_en_q    <= snap_en_d;
      out_q        <= out_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out        = out_q;
  assign sel        = sel_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_segment_scan_mux.sv
// Scoreboard bench for segment_scan_mux: one DUT with BLANK_CYC=1, one with BLANK_CYC=0, checked every cycle.
module tb_segment_scan_mux;

  localparam int N  = 5;
  localparam int CD = 4;

  logic        clk;
  logic        rst_n;
  logic [19:0] din;
  logic [4:0]  den;
  logic        load;
  logic [3:0]  out_a, out_b;
  logic [2:0]  sel_a, sel_b;
  logic [4:0]  an_a, an_b;
  logic        fd_a, fd_b;

  segment_scan_mux #(.NUM_DIGITS(N), .DIGIT_W(4), .SEL_W(3), .CLK_DIV(CD), .BLANK_CYC(1), .BLANK_CODE(11)) u_dut (
    .clk(clk), .rst_n(rst_n), .digits_in(din), .digit_en(den), .load(load),
    .out(out_a), .sel(sel_a), .an_n(an_a), .frame_done(fd_a));

  segment_scan_mux #(.NUM_DIGITS(N), .DIGIT_W(4), .SEL_W(3), .CLK_DIV(CD), .BLANK_CYC(0), .BLANK_CODE(11)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .digits_in(din), .digit_en(den), .load(load),
    .out(out_b), .sel(sel_b), .an_n(an_b), .frame_done(fd_b));

  typedef struct {
    logic [3:0] out;
    logic [4:0] an;
    logic [2:0] sel;
    logic       fd;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [19:0] m_dig;
  logic [4:0]  m_en;
  int          t;
  int          n_pass;
  int          n_total;
  int          n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] lzm(input logic [19:0] d);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    int h;
    logic [4:0] m;
    h = 0;
    for (int i = 0; i < 5; i++) if (d[4*i +: 4] != 4'd0) h = i;
    m = 5'b00000;
    for (int i = 0; i < 5; i++) m[i] = (i <= h);
    return m;
`else
    return 5'b11111;
`endif
  endfunction

  // Reference: position inside the frame is derived from cycles since scanning started.
  function automatic exp_t model(input int tt, input int p, input logic [19:0] d, input logic [4:0] en);
    exp_t e;
    int dig;
    logic [4:0] m;
    dig   = (tt / p) % N;
    m     = en & lzm(d);
    e.sel = 3'(dig);
    e.fd  = (tt > 0) && ((tt % (N * p)) == 0);
    if (((tt % p) < CD) && m[dig]) begin
      e.out = d[4*dig +: 4];
      e.an  = ~(5'b00001 << dig);
    end else begin
      e.out = 4'd11;
      e.an  = 5'b11111;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_a"}, 32'(out_a), 32'd11);
    chk({tag, "_an_a"},  32'(an_a),  32'h1f);
    chk({tag, "_sel_a"}, 32'(sel_a), 32'd0);
    chk({tag, "_fd_a"},  32'(fd_a),  32'd0);
    chk({tag, "_out_b"}, 32'(out_b), 32'd11);
    chk({tag, "_an_b"},  32'(an_b),  32'h1f);
    chk({tag, "_sel_b"}, 32'(sel_b), 32'd0);
  endtask

  task automatic tick();
    exp_t ea, eb;
    @(posedge clk);
    if (!rst_n) begin
      m_dig  = 20'h0;
      m_en   = 5'b0;
      t      = 0;
      ea.out = 4'd11; ea.an = 5'b11111; ea.sel = 3'd0; ea.fd = 1'b0;
      eb     = ea;
    end else begin
      if (load) begin
        m_dig = din;
        m_en  = den;
      end
      ea = model(t, CD + 1, m_dig, m_en);
      eb = model(t, CD, m_dig, m_en);
      t++;
    end
    q_a.push_back(ea);
    q_b.push_back(eb);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk("out_a", 32'(out_a), 32'(ea.out));
    chk("an_a",  32'(an_a),  32'(ea.an));
    chk("sel_a", 32'(sel_a), 32'(ea.sel));
    chk("fd_a",  32'(fd_a),  32'(ea.fd));
    chk("out_b", 32'(out_b), 32'(eb.out));
    chk("an_b",  32'(an_b),  32'(eb.an));
    chk("sel_b", 32'(sel_b), 32'(eb.sel));
    chk("fd_b",  32'(fd_b),  32'(eb.fd));
    chk("onehot_a", 32'($countones(~an_a) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0; t = 0;
    m_dig = 20'h0; m_en = 5'b0;
    rst_n = 1'b0; load = 1'b0; din = 20'h0; den = 5'b0;
    run(2);
    chk_reset("reset");

    // Basic scan of 0x54321, all digits enabled, for two frames.
    rst_n = 1'b1; load = 1'b1; din = 20'h54321; den = 5'b11111;
    tick();
    load = 1'b0;
    run(50);

    // Disable digit 2; the slot is still consumed.
    load = 1'b1; den = 5'b11011;
    tick();
    load = 1'b0;
    run(30);

    // Mid-dwell load captured at the end of digit 0's second cycle.
    for (int k = 0; k < 30 && (t % 25) != 2; k++) tick();
    chk("align_dwell", 32'(t % 25), 32'd2);
    load = 1'b1; din = 20'h00009; den = 5'b11111;
    tick();
    load = 1'b0;
    run(30);

    // Async reset between edges while digit 3 is showing.
    load = 1'b1; din = 20'h54321; den = 5'b11111;
    tick();
    load = 1'b0;
    for (int k = 0; k < 30 && (t % 25) != 17; k++) tick();
    chk("align_rst", 32'(t % 25), 32'd17);
    chk("pre_rst_sel", 32'(sel_a), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    run(2);
    rst_n = 1'b1; load = 1'b1; din = 20'h54321; den = 5'b11111;
    tick();
    load = 1'b0;
    run(55);

    // Leading-zero patterns.
    load = 1'b1; din = 20'h00050; den = 5'b11111;
    tick();
    load = 1'b0;
    run(26);
    load = 1'b1; din = 20'h00000;
    tick();
    load = 1'b0;
    run(26);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
